// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the two handshakes around the fetch stage:
//     - instruction-memory read port (req/gnt, then rvalid/rdata)
//     - decode port (valid/ready, with the branch redirect that decode
//       resolves in the handshake cycle)
//
//   Signals
//     imem_req      fetch -> mem     read request
//     imem_addr     fetch -> mem     request address
//     imem_gnt      mem   -> fetch   request accepted
//     imem_rvalid   mem   -> fetch   read data valid
//     imem_rdata    mem   -> fetch   read data
//     instr_valid   fetch -> decode  instruction available
//     instr         fetch -> decode  fetched instruction
//     instr_pc      fetch -> decode  PC of the fetched instruction
//     instr_ready   decode -> fetch  decode accepts instruction
//     branch_taken  decode -> fetch  redirect for the instruction in handshake
//     branch_target decode -> fetch  redirect address
//
//   Modports
//     master : the fetch unit
//     slave  : the memory/decode side (testbench or surrounding pipeline)
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage sitting directly upstream of the PC register.
//   Reads the current PC (pc_in_i), fetches one instruction over the
//   req/gnt/rvalid memory handshake, offers it to decode over valid/ready,
//   and on the decode handshake writes the next PC (PC+4 or the resolved
//   branch target) back to the PC register with a single-cycle pulse.
//
//   Ports
//     clk            clock
//     reset          asynchronous, active-high reset
//     pc_in_i        current PC (PC register output)
//     pc_write_o     PC register write enable, one-cycle pulse per retired fetch
//     pc_next_o      next-PC value for the PC register input
//     fetch_count_o  number of completed decode handshakes (wraps)
//     fetch_err_o    misaligned-redirect trap flag
//     fetch_bus      fetch_unit_if.master: memory and decode handshakes
//
//   Configuration
//     FETCH_MISALIGN_TRAP_EN  when defined, a taken redirect whose target is
//                             not 4-byte aligned parks the unit in S_ERR with
//                             fetch_err_o=1 until reset. When undefined,
//                             fetch_err_o is 0 and the target's low two bits
//                             are cleared.
//
//   Cycle budget: at least four cycles per instruction -- a settle cycle in
//   S_REQ while the PC register absorbs the pc_write pulse, the request
//   cycle, the wait for rvalid, and the decode hold.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in_i,
  output logic              pc_write_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic [CNT_W-1:0]  fetch_count_o,
  output logic              fetch_err_o,
  fetch_unit_if.master      fetch_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
    , S_ERR
`endif
  } state_e;

  state_e             state_q;
  logic               pc_write_q;
  logic [ADDR_W-1:0]  pc_next_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic               instr_valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic [CNT_W-1:0]   fetch_count_q;

  logic               req_d;
  logic [ADDR_W-1:0]  seq_pc_d;
  logic [ADDR_W-1:0]  target_d;
  logic [ADDR_W-1:0]  next_pc_d;
  logic               misalign_d;

  // The first S_REQ cycle after a handshake coincides with the pc_write
  // pulse; pc_in_i still shows the old PC then, so the request is held off
  // until the PC register has taken the new value.
  assign req_d = (state_q == S_REQ) && !pc_write_q;

  // Sequential PC wraps naturally at 2^ADDR_W.
  assign seq_pc_d = instr_pc_q + ADDR_W'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target_d   = fetch_bus.branch_target;
  assign misalign_d = fetch_bus.branch_taken &&
                      (fetch_bus.branch_target[1:0] != 2'b00);
  reg err_q;
  assign fetch_err_o = err_q;
`else
  // Without the trap a misaligned redirect is silently realigned.
  assign target_d    = fetch_bus.branch_target & ~ADDR_W'(3);
  assign misalign_d  = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  assign next_pc_d = fetch_bus.branch_taken ? target_d : seq_pc_d;

  assign fetch_bus.imem_req    = req_d;
  assign fetch_bus.imem_addr   = pc_in_i;
  assign fetch_bus.instr_valid = instr_valid_q;
  assign fetch_bus.instr       = instr_q;
  assign fetch_bus.instr_pc    = instr_pc_q;

  assign pc_write_o    = pc_write_q;
  assign pc_next_o     = pc_next_q;
  assign fetch_count_o = fetch_count_q;

  // NOTE: all state lives in one clocked block written with non-blocking
  // assignments, so every branch reads the pre-edge values and the order of
  // statements inside the block does not change the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data/address registers are reset as well, not just the
      // control bits, so decode never sees stale contents after reset.
      state_q       <= S_IDLE;
      pc_write_q    <= 1'b0;
      pc_next_q     <= '0;
      req_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q         <= 1'b0;
`endif
    end else begin
      // NOTE: default-low here makes pc_write a single-cycle pulse; only the
      // handshake branch below raises it.
      pc_write_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
        end

        S_REQ: begin
          // The address is captured at grant so instr_pc reports the address
          // actually requested, independent of later pc_in_i activity.
          if (req_d && fetch_bus.imem_gnt) begin
            req_addr_q <= pc_in_i;
            state_q    <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Reached only on the edge after grant, so an rvalid that arrived
          // together with gnt is never seen here.
          if (fetch_bus.imem_rvalid) begin
            instr_q       <= fetch_bus.imem_rdata;
            instr_pc_q    <= req_addr_q;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (fetch_bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            fetch_count_q <= fetch_count_q + CNT_W'(1);
            if (misalign_d) begin
`ifdef FETCH_MISALIGN_TRAP_EN
              err_q   <= 1'b1;
              state_q <= S_ERR;
`endif
            end else begin
              pc_next_q  <= next_pc_d;
              pc_write_q <= 1'b1;
              state_q    <= S_REQ;
            end
          end
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        S_ERR: begin
          state_q <= S_ERR;
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
